// File: rtl/exec_pkg.sv
// Shared types for the lane-serialised execute stage: FSM states, ALU opcodes
// and the control bundle that travels alongside the result.
package exec_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } ex_state_t;

    localparam logic [3:0] ALU_PASS = 4'b0000;
    localparam logic [3:0] ALU_ADD  = 4'b0001;
    localparam logic [3:0] ALU_SUB  = 4'b0010;
    localparam logic [3:0] ALU_AND  = 4'b0011;
    localparam logic [3:0] ALU_OR   = 4'b0100;
    localparam logic [3:0] ALU_XOR  = 4'b0101;
    localparam logic [3:0] ALU_SHL  = 4'b0110;
    localparam logic [3:0] ALU_SHR  = 4'b0111;
    localparam logic [3:0] ALU_MUL  = 4'b1000;

    typedef struct packed {
        logic [3:0] rc;
        logic       reg_write;
        logic       mem_to_reg;
        logic       mem_write;
        logic       branch_flag;
        logic [1:0] op_type;
        logic [3:0] op_code;
        logic       mode_sel;
    } ex_ctrl_t;

endpackage

// File: rtl/vec_lane_alu.sv
// Single-lane combinational ALU, N-bit wraparound arithmetic; unknown opcodes give zero.
module vec_lane_alu
    import exec_pkg::*;
#(
    parameter int N = 24
) (
    input  logic [3:0]   op,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic [N-1:0] y
);

    always_comb begin
        // NOTE: y gets a value before the case so every path drives it and no latch is inferred.
        y = '0;
        case (op)
            ALU_PASS: y = a;
            ALU_ADD:  y = a + b;
            ALU_SUB:  y = a - b;
            ALU_AND:  y = a & b;
            ALU_OR:   y = a | b;
            ALU_XOR:  y = a ^ b;
            ALU_SHL:  y = a << b[4:0];
            ALU_SHR:  y = a >> b[4:0];
            ALU_MUL:  y = a * b;
            default:  y = '0;
        endcase
    end

endmodule

// File: rtl/exec_vec_seq.sv
// Execute stage: scalar ops finish in one cycle, vector ops run P lanes per beat over M/P beats,
// with valid/ready on both sides and a synchronous flush.
module exec_vec_seq
    import exec_pkg::*;
#(
    parameter int N = 24,
    parameter int M = 6,
    parameter int P = 2
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           flush,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic           modeSel,
    input  logic [3:0]     aluControl,
    input  logic           immSrc,
    input  logic           Fa,
    input  logic           Fb,
    input  logic           Fc,
    input  logic [N-1:0]   rd1,
    input  logic [N-1:0]   rd2,
    input  logic [N-1:0]   rd3,
    input  logic [N-1:0]   imm,
    input  logic [M*N-1:0] rdv1,
    input  logic [M*N-1:0] rdv2,
    input  logic [M*N-1:0] rdv3,
    input  logic [M*N-1:0] Forward1,
    input  logic [M*N-1:0] Forward2,
    input  logic [M*N-1:0] Forward3,
    input  logic [3:0]     Rc,
    input  logic           regWrite,
    input  logic           memToReg,
    input  logic           memWrite,
    input  logic           branchFlag,
    input  logic [1:0]     opType,
    input  logic [3:0]     opCode,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [M*N-1:0] result,
    output logic [M*N-1:0] storeData,
    output logic           zeroFlag,
    output logic           negFlag,
    output logic [3:0]     o_Rc,
    output logic           o_regWrite,
    output logic           o_memToReg,
    output logic           o_memWrite,
    output logic           o_branchFlag,
    output logic [1:0]     o_opType,
    output logic [3:0]     o_opCode,
    output logic           o_modeSel
);

    localparam int W      = M * N;
    localparam int BEATS  = M / P;
    localparam int BEAT_W = $clog2(BEATS) + 1;
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);

    if (M % P != 0) begin : g_bad_p
        $error("exec_vec_seq: P must divide M");
    end

    ex_state_t         state_q, state_d;
    logic [BEAT_W-1:0] beat_q, beat_d;
    logic [W-1:0]      a_q, a_d, b_q, b_d;
    logic [W-1:0]      result_q, result_d, store_q, store_d;
    logic [3:0]        alu_op_q, alu_op_d;
    ex_ctrl_t          ctrl_q, ctrl_d;
    logic              zero_q, zero_d, neg_q, neg_d;

    logic [N-1:0]      scal_a, scal_b;
    logic [W-1:0]      vec_a, vec_b, store_sel;
    ex_ctrl_t          ctrl_in;
    logic              accept, running;
    logic [3:0]        lane_op;
    logic [P*N-1:0]    lane_a, lane_b, lane_y;

    assign in_ready  = (state_q == IDLE) | ((state_q == DONE) & out_ready);
    assign accept    = in_valid & in_ready & ~flush;
    assign out_valid = (state_q == DONE);
    assign running   = (state_q == RUN);

    assign ctrl_in = '{rc: Rc, reg_write: regWrite, mem_to_reg: memToReg, mem_write: memWrite,
                       branch_flag: branchFlag, op_type: opType, op_code: opCode,
                       mode_sel: modeSel};

    // Operand selection; scalar forwarding uses only the low element of the forward buses.
    always_comb begin
        scal_a    = Fa ? Forward1[N-1:0] : rd1;
        scal_b    = Fb ? Forward2[N-1:0] : (immSrc ? imm : rd2);
        vec_a     = Fa ? Forward1 : rdv1;
        vec_b     = Fb ? Forward2 : rdv2;
        store_sel = '0;
        if (modeSel) store_sel = Fc ? Forward3 : rdv3;
        else         store_sel[N-1:0] = Fc ? Forward3[N-1:0] : rd3;
    end

    // In RUN the lanes see the latched operand slice for this beat; otherwise lane 0
    // computes a scalar op straight from the live operands.
    always_comb begin
        lane_op = running ? alu_op_q : aluControl;
        lane_a  = '0;
        lane_b  = '0;
        for (int i = 0; i < P; i++) begin
            if (running) begin
                lane_a[i*N +: N] = a_q[(int'(beat_q) * P + i) * N +: N];
                lane_b[i*N +: N] = b_q[(int'(beat_q) * P + i) * N +: N];
            end else if (i == 0) begin
                lane_a[N-1:0] = scal_a;
                lane_b[N-1:0] = scal_b;
            end
        end
    end

    for (genvar g = 0; g < P; g++) begin : g_lane
        vec_lane_alu #(.N(N)) u_alu (
            .op (lane_op),
            .a  (lane_a[g*N +: N]),
            .b  (lane_b[g*N +: N]),
            .y  (lane_y[g*N +: N])
        );
    end

    always_comb begin
        state_d  = state_q;
        beat_d   = beat_q;
        a_d      = a_q;
        b_d      = b_q;
        result_d = result_q;
        store_d  = store_q;
        alu_op_d = alu_op_q;
        ctrl_d   = ctrl_q;
        zero_d   = zero_q;
        neg_d    = neg_q;

        case (state_q)
            IDLE, DONE: begin
                if (state_q == DONE && out_ready) state_d = IDLE;
                if (accept) begin
                    ctrl_d   = ctrl_in;
                    alu_op_d = aluControl;
                    store_d  = store_sel;
                    result_d = '0;
                    if (modeSel) begin
                        a_d     = vec_a;
                        b_d     = vec_b;
                        beat_d  = '0;
                        state_d = RUN;
                    end else begin
                        result_d[N-1:0] = lane_y[N-1:0];
                        zero_d          = (lane_y[N-1:0] == '0);
                        neg_d           = lane_y[N-1];
                        state_d         = DONE;
                    end
                end
            end
            RUN: begin
                for (int i = 0; i < P; i++)
                    result_d[(int'(beat_q) * P + i) * N +: N] = lane_y[i*N +: N];
                beat_d = beat_q + BEAT_W'(1);
                if (beat_q == LAST_BEAT) begin
                    zero_d  = (result_d == '0);
                    neg_d   = result_d[N-1];
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Flush wins over both accept and completion, and drops the whole bundle.
        if (flush) begin
            state_d  = IDLE;
            beat_d   = '0;
            result_d = '0;
            store_d  = '0;
            alu_op_d = '0;
            ctrl_d   = '0;
            zero_d   = 1'b0;
            neg_d    = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            beat_q   <= '0;
            a_q      <= '0;
            b_q      <= '0;
            result_q <= '0;
            store_q  <= '0;
            alu_op_q <= '0;
            ctrl_q   <= '0;
            zero_q   <= 1'b0;
            neg_q    <= 1'b0;
        end else begin
            // NOTE: non-blocking so every register updates together from its _d value.
            state_q  <= state_d;
            beat_q   <= beat_d;
            a_q      <= a_d;
            b_q      <= b_d;
            result_q <= result_d;
            store_q  <= store_d;
            alu_op_q <= alu_op_d;
            ctrl_q   <= ctrl_d;
            zero_q   <= zero_d;
            neg_q    <= neg_d;
        end
    end

    assign result       = result_q;
    assign storeData    = store_q;
    assign zeroFlag     = zero_q;
    assign negFlag      = neg_q;
    assign o_Rc         = ctrl_q.rc;
    assign o_regWrite   = ctrl_q.reg_write;
    assign o_memToReg   = ctrl_q.mem_to_reg;
    assign o_memWrite   = ctrl_q.mem_write;
    assign o_branchFlag = ctrl_q.branch_flag;
    assign o_opType     = ctrl_q.op_type;
    assign o_opCode     = ctrl_q.op_code;
    assign o_modeSel    = ctrl_q.mode_sel;

endmodule

// File: tb/tb_exec_vec_seq.sv
// Directed bench for exec_vec_seq: reset, scalar ops, vector beats, forwarding,
// backpressure with back-to-back accept, flush and asynchronous reset mid-run.
module tb_exec_vec_seq;

    localparam int N = 24;
    localparam int M = 6;
    localparam int P = 2;
    localparam int W = M * N;

    logic         clk = 1'b0;
    logic         rst;
    logic         flush, in_valid, in_ready, modeSel, immSrc, Fa, Fb, Fc;
    logic [3:0]   aluControl, Rc, opCode;
    logic [N-1:0] rd1, rd2, rd3, imm;
    logic [W-1:0] rdv1, rdv2, rdv3, Forward1, Forward2, Forward3;
    logic         regWrite, memToReg, memWrite, branchFlag;
    logic [1:0]   opType;
    logic         out_valid, out_ready;
    logic [W-1:0] result, storeData;
    logic         zeroFlag, negFlag;
    logic [3:0]   o_Rc, o_opCode;
    logic         o_regWrite, o_memToReg, o_memWrite, o_branchFlag, o_modeSel;
    logic [1:0]   o_opType;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    exec_vec_seq #(.N(N), .M(M), .P(P)) dut (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .modeSel(modeSel), .aluControl(aluControl), .immSrc(immSrc),
        .Fa(Fa), .Fb(Fb), .Fc(Fc), .rd1(rd1), .rd2(rd2), .rd3(rd3), .imm(imm),
        .rdv1(rdv1), .rdv2(rdv2), .rdv3(rdv3),
        .Forward1(Forward1), .Forward2(Forward2), .Forward3(Forward3),
        .Rc(Rc), .regWrite(regWrite), .memToReg(memToReg), .memWrite(memWrite),
        .branchFlag(branchFlag), .opType(opType), .opCode(opCode),
        .out_valid(out_valid), .out_ready(out_ready), .result(result), .storeData(storeData),
        .zeroFlag(zeroFlag), .negFlag(negFlag), .o_Rc(o_Rc), .o_regWrite(o_regWrite),
        .o_memToReg(o_memToReg), .o_memWrite(o_memWrite), .o_branchFlag(o_branchFlag),
        .o_opType(o_opType), .o_opCode(o_opCode), .o_modeSel(o_modeSel)
    );

    // Element 5 first, element 0 last, matching {e5,...,e0} concatenation order.
    function automatic logic [W-1:0] vec6(input int e5, input int e4, input int e3,
                                          input int e2, input int e1, input int e0);
        return {N'(e5), N'(e4), N'(e3), N'(e2), N'(e1), N'(e0)};
    endfunction

    function automatic logic [W-1:0] rand_w();
        logic [W-1:0] v;
        for (int i = 0; i < M; i++) v[i*N +: N] = N'($urandom());
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        flush = 0; in_valid = 0; modeSel = 0; aluControl = 0; immSrc = 0;
        Fa = 0; Fb = 0; Fc = 0; rd1 = 0; rd2 = 0; rd3 = 0; imm = 0;
        rdv1 = 0; rdv2 = 0; rdv3 = 0; Forward1 = 0; Forward2 = 0; Forward3 = 0;
        Rc = 0; regWrite = 0; memToReg = 0; memWrite = 0; branchFlag = 0;
        opType = 0; opCode = 0; out_ready = 1;
    endtask

    task automatic randomize_inputs();
        flush = 1'($urandom()); in_valid = 1'($urandom()); modeSel = 1'($urandom());
        aluControl = 4'($urandom()); immSrc = 1'($urandom());
        Fa = 1'($urandom()); Fb = 1'($urandom()); Fc = 1'($urandom());
        rd1 = N'($urandom()); rd2 = N'($urandom()); rd3 = N'($urandom()); imm = N'($urandom());
        rdv1 = rand_w(); rdv2 = rand_w(); rdv3 = rand_w();
        Forward1 = rand_w(); Forward2 = rand_w(); Forward3 = rand_w();
        Rc = 4'($urandom()); regWrite = 1'($urandom()); memToReg = 1'($urandom());
        memWrite = 1'($urandom()); branchFlag = 1'($urandom());
        opType = 2'($urandom()); opCode = 4'($urandom()); out_ready = 1'($urandom());
    endtask

    // Accept one vector op and advance to the cycle where the bundle is presented.
    task automatic run_vec(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        modeSel = 1; aluControl = op; rdv1 = a; rdv2 = b; in_valid = 1;
        tick();
        in_valid = 0;
        for (int c = 0; c < M / P; c++) tick();
    endtask

    task automatic test_reset();
        for (int c = 0; c < 3; c++) begin
            randomize_inputs();
            @(negedge clk);
            n_vec++;
            if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
                n_err++;
                $display("FAIL reset_handshake: out_valid=%b in_ready=%b required 0/1", out_valid, in_ready);
            end
            n_vec++;
            if ({result, storeData, zeroFlag, negFlag, o_Rc, o_regWrite, o_memToReg, o_memWrite,
                 o_branchFlag, o_opType, o_opCode, o_modeSel} !== '0) begin
                n_err++;
                $display("FAIL reset_outputs: result=%h storeData=%h o_Rc=%h required all zero",
                         result, storeData, o_Rc);
            end
        end
        idle_inputs();
        rst = 1;
    endtask

    typedef struct packed {
        logic [3:0]   op;
        logic [N-1:0] a, b, im;
        logic         isrc;
        logic [N-1:0] y;
        logic         z, n;
    } sop_t;

    task automatic test_scalar_ops();
        sop_t t [8];
        t = '{'{4'h1, 24'd1,       24'd5,       24'd0, 1'b0, 24'd6,       1'b0, 1'b0},
              '{4'h2, 24'd3,       24'd5,       24'd0, 1'b0, 24'hFFFFFE,  1'b0, 1'b1},
              '{4'h6, 24'd3,       24'd99,      24'd4, 1'b1, 24'd48,      1'b0, 1'b0},
              '{4'h7, 24'h800000,  24'd23,      24'd0, 1'b0, 24'd1,       1'b0, 1'b0},
              '{4'h8, 24'h001000,  24'h001000,  24'd0, 1'b0, 24'd0,       1'b1, 1'b0},
              '{4'h4, 24'hF00000,  24'h0000FF,  24'd0, 1'b0, 24'hF000FF,  1'b0, 1'b1},
              '{4'h3, 24'hFF00FF,  24'h0F0F0F,  24'd0, 1'b0, 24'h0F000F,  1'b0, 1'b0},
              '{4'hF, 24'd5,       24'd5,       24'd0, 1'b0, 24'd0,       1'b1, 1'b0}};
        for (int i = 0; i < 8; i++) begin
            modeSel = 0; aluControl = t[i].op; rd1 = t[i].a; rd2 = t[i].b; imm = t[i].im;
            immSrc = t[i].isrc; Rc = 4'(i); rdv1 = rand_w(); rdv2 = rand_w(); in_valid = 1;
            tick();
            in_valid = 0;
            n_vec++;
            if (out_valid !== 1'b1 || result !== W'(t[i].y) || zeroFlag !== t[i].z ||
                negFlag !== t[i].n || o_Rc !== 4'(i)) begin
                n_err++;
                $display("FAIL scalar_op%0d: valid=%b result=%h z=%b n=%b rc=%h required 1/%h/%b/%b/%h",
                         i, out_valid, result, zeroFlag, negFlag, o_Rc, t[i].y, t[i].z, t[i].n, 4'(i));
            end
            tick();
        end
        idle_inputs();
    endtask

    task automatic test_vector_add();
        modeSel = 1; aluControl = 4'h1; in_valid = 1;
        rdv1 = vec6(6, 5, 4, 3, 2, 1); rdv2 = vec6(12, 11, 10, 9, 8, 7);
        rdv3 = vec6(60, 50, 40, 30, 20, 10);
        tick();
        in_valid = 0; rdv1 = rand_w(); rdv2 = rand_w(); aluControl = 4'h2;
        for (int c = 0; c < M / P; c++) begin
            n_vec++;
            if (in_ready !== 1'b0 || out_valid !== 1'b0) begin
                n_err++;
                $display("FAIL vec_run_cycle%0d: in_ready=%b out_valid=%b required 0/0", c, in_ready, out_valid);
            end
            tick();
        end
        n_vec++;
        if (out_valid !== 1'b1 || result !== vec6(18, 16, 14, 12, 10, 8) ||
            storeData !== vec6(60, 50, 40, 30, 20, 10) || zeroFlag !== 1'b0 || negFlag !== 1'b0) begin
            n_err++;
            $display("FAIL vec_add: valid=%b result=%h store=%h z=%b n=%b required 1/%h/%h/0/0",
                     out_valid, result, storeData, zeroFlag, negFlag,
                     vec6(18, 16, 14, 12, 10, 8), vec6(60, 50, 40, 30, 20, 10));
        end
        tick();
        idle_inputs();
    endtask

    task automatic test_vector_flags();
        run_vec(4'h2, vec6(1, 0, 0, 0, 0, 3), vec6(0, 0, 0, 0, 0, 5));
        n_vec++;
        if (result !== vec6(1, 0, 0, 0, 0, 24'hFFFFFE) || zeroFlag !== 1'b0 || negFlag !== 1'b1) begin
            n_err++;
            $display("FAIL vec_sub_flags: result=%h z=%b n=%b required %h/0/1",
                     result, zeroFlag, negFlag, vec6(1, 0, 0, 0, 0, 24'hFFFFFE));
        end
        tick();
        run_vec(4'h5, vec6(9, 8, 7, 6, 5, 4), vec6(9, 8, 7, 6, 5, 4));
        n_vec++;
        if (result !== '0 || zeroFlag !== 1'b1 || negFlag !== 1'b0) begin
            n_err++;
            $display("FAIL vec_xor_zero: result=%h z=%b n=%b required 0/1/0", result, zeroFlag, negFlag);
        end
        tick();
        idle_inputs();
    endtask

    task automatic test_forwarding();
        Fa = 1; Forward1 = vec6(24, 23, 22, 21, 20, 19); Fc = 1; Forward3 = vec6(36, 35, 34, 33, 32, 31);
        rdv3 = rand_w(); regWrite = 1; memWrite = 1; Rc = 4'd3;
        run_vec(4'h0, rand_w(), rand_w());
        n_vec++;
        if (result !== vec6(24, 23, 22, 21, 20, 19) || storeData !== vec6(36, 35, 34, 33, 32, 31) ||
            o_regWrite !== 1'b1 || o_memWrite !== 1'b1 || o_modeSel !== 1'b1 || o_Rc !== 4'd3) begin
            n_err++;
            $display("FAIL vec_forward: result=%h store=%h ctrl=%b%b%b rc=%h required %h/%h/111/3",
                     result, storeData, o_regWrite, o_memWrite, o_modeSel, o_Rc,
                     vec6(24, 23, 22, 21, 20, 19), vec6(36, 35, 34, 33, 32, 31));
        end
        tick();
        // Scalar: forwarded B and store data use only element 0 of the forward buses.
        idle_inputs();
        modeSel = 0; aluControl = 4'h1; rd1 = 24'd7; rd2 = 24'd1000; Fb = 1; Fc = 1;
        Forward2 = vec6(77, 77, 77, 77, 77, 10); Forward3 = vec6(5, 5, 5, 5, 5, 24'hABCDEF);
        in_valid = 1;
        tick();
        in_valid = 0;
        n_vec++;
        if (out_valid !== 1'b1 || result !== W'(24'd17) || storeData !== W'(24'hABCDEF) || o_modeSel !== 1'b0) begin
            n_err++;
            $display("FAIL scalar_forward: valid=%b result=%h store=%h mode=%b required 1/11/abcdef/0",
                     out_valid, result, storeData, o_modeSel);
        end
        tick();
        idle_inputs();
    endtask

    task automatic test_back_to_back();
        out_ready = 0; modeSel = 0; aluControl = 4'h5; rd1 = 24'h00FF00; rd2 = 24'h0F0F0F;
        Rc = 4'd15; opCode = 4'd7; opType = 2'd2; branchFlag = 1; in_valid = 1;
        tick();
        in_valid = 0; rd1 = 24'h123456; Rc = 4'd1; opCode = 4'd0; opType = 2'd0; aluControl = 4'h1;
        for (int c = 0; c < 4; c++) begin
            n_vec++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || result !== W'(24'h0FF00F) || o_Rc !== 4'd15 ||
                o_opCode !== 4'd7 || o_opType !== 2'd2 || o_branchFlag !== 1'b1) begin
                n_err++;
                $display("FAIL backpressure_hold%0d: valid=%b rdy=%b result=%h rc=%h opc=%h opt=%h br=%b required 1/0/0ff00f/f/7/2/1",
                         c, out_valid, in_ready, result, o_Rc, o_opCode, o_opType, o_branchFlag);
            end
            tick();
        end
        out_ready = 1; in_valid = 1; rd1 = 24'd100; rd2 = 24'd23; Rc = 4'd4; opCode = 4'd1; branchFlag = 0;
        #1;
        n_vec++;
        if (in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL b2b_in_ready: got %b required 1", in_ready);
        end
        tick();
        in_valid = 0;
        n_vec++;
        if (out_valid !== 1'b1 || result !== W'(24'd123) || o_Rc !== 4'd4 || o_opCode !== 4'd1) begin
            n_err++;
            $display("FAIL b2b_second: valid=%b result=%h rc=%h opc=%h required 1/7b/4/1",
                     out_valid, result, o_Rc, o_opCode);
        end
        tick();
        n_vec++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL b2b_idle: valid=%b rdy=%b required 0/1", out_valid, in_ready);
        end
        idle_inputs();
    endtask

    task automatic test_flush();
        modeSel = 1; aluControl = 4'h1; Rc = 4'd9; in_valid = 1;
        rdv1 = vec6(6, 5, 4, 3, 2, 1); rdv2 = vec6(12, 11, 10, 9, 8, 7);
        tick();
        in_valid = 0;
        tick();
        flush = 1;
        tick();
        flush = 0;
        n_vec++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || result !== '0 || o_Rc !== 4'd0) begin
            n_err++;
            $display("FAIL flush_run: valid=%b rdy=%b result=%h rc=%h required 0/1/0/0",
                     out_valid, in_ready, result, o_Rc);
        end
        for (int c = 0; c < 4; c++) begin
            n_vec++;
            if (out_valid !== 1'b0) begin
                n_err++;
                $display("FAIL flush_run_quiet%0d: valid=%b required 0", c, out_valid);
            end
            tick();
        end
        modeSel = 0; aluControl = 4'h1; rd1 = 24'd1; rd2 = 24'd1; Rc = 4'd5; in_valid = 1; flush = 1;
        tick();
        in_valid = 0; flush = 0;
        n_vec++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || result !== '0 || o_Rc !== 4'd0) begin
            n_err++;
            $display("FAIL flush_idle: valid=%b rdy=%b result=%h rc=%h required 0/1/0/0",
                     out_valid, in_ready, result, o_Rc);
        end
        tick();
        n_vec++;
        if (out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL flush_idle_quiet: valid=%b required 0", out_valid);
        end
        idle_inputs();
    endtask

    task automatic test_reset_mid_run();
        modeSel = 1; aluControl = 4'h1; Rc = 4'd6; in_valid = 1;
        rdv1 = vec6(6, 5, 4, 3, 2, 1); rdv2 = vec6(12, 11, 10, 9, 8, 7);
        tick();
        in_valid = 0;
        tick();
        #2 rst = 0;
        #1;
        n_vec++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || result !== '0 || o_Rc !== 4'd0 || o_modeSel !== 1'b0) begin
            n_err++;
            $display("FAIL async_reset: valid=%b rdy=%b result=%h rc=%h mode=%b required 0/1/0/0/0",
                     out_valid, in_ready, result, o_Rc, o_modeSel);
        end
        @(negedge clk);
        rst = 1;
        for (int c = 0; c < 4; c++) begin
            tick();
            n_vec++;
            if (out_valid !== 1'b0 || result !== '0) begin
                n_err++;
                $display("FAIL async_reset_quiet%0d: valid=%b result=%h required 0/0", c, out_valid, result);
            end
        end
        idle_inputs();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not reach its summary");
        $fatal(1);
    end

    initial begin
        idle_inputs();
        rst = 1;
        #2 rst = 0;
        test_reset();
        tick();
        test_scalar_ops();
        test_vector_add();
        test_vector_flags();
        test_forwarding();
        test_back_to_back();
        test_flush();
        test_reset_mid_run();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
